// File: rtl/case_1_sdiv_10s_10s_10_seq_if.sv
// Purpose : scheduler-facing bundle for the sequential signed divider.
// Latency : n/a (wiring only).
// Backpressure: none; ce stalls the whole operator, done is held across a stall.
//
// Signals:
//   ce        clock enable, low freezes the operator
//   start     one-cycle issue request (sampled only with ce=1)
//   din0/din1 dividend / divisor, two's complement
//   done      one-ce-cycle result-valid pulse
//   quotient  signed quotient, remainder signed remainder (sign of dividend)
interface case_1_sdiv_10s_10s_10_seq_if #(
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 10
);
    logic                  ce;
    logic                  start;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic                  done;
    logic [dout_WIDTH-1:0] quotient;
    logic [din1_WIDTH-1:0] remainder;

    // Scheduler side drives requests and consumes results.
    modport master (
        output ce, start, din0, din1,
        input  done, quotient, remainder
    );

    // Divider side.
    modport slave (
        input  ce, start, din0, din1,
        output done, quotient, remainder
    );
endinterface

// File: rtl/case_1_sdiv_10s_10s_10_seq.sv
// Purpose : signed truncating divider, radix-2 restoring, one quotient bit per ce cycle.
// Latency : done rises din0_WIDTH ce cycles after start is accepted; one result per din0_WIDTH+1 cycles.
// Backpressure: ce=0 freezes all state (done stretches); start is ignored while busy.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; aborts any operation in flight
//   bus    slave side of case_1_sdiv_10s_10s_10_seq_if (ce, start, din0, din1,
//          done, quotient, remainder)
module case_1_sdiv_10s_10s_10_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 10,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 10
) (
    input logic                         clk,
    input logic                         reset,
    case_1_sdiv_10s_10s_10_seq_if.slave bus
);

    // Partial remainder must hold any divisor magnitude and, on divide by
    // zero, the entire dividend magnitude (nothing is ever subtracted).
    localparam int RW = (din0_WIDTH > din1_WIDTH) ? din0_WIDTH : din1_WIDTH;
    localparam int CW = $clog2(din0_WIDTH + 1);

    if (ID < 0 || din0_WIDTH < 2 || din1_WIDTH < 1 || dout_WIDTH < 1) begin : g_param_check
        $error("case_1_sdiv_10s_10s_10_seq: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [din0_WIDTH-1:0] dvd;      // dividend magnitude, quotient bits shift in at the LSB
    logic [din1_WIDTH-1:0] dvs;      // divisor magnitude
    logic [RW-1:0]         rem;      // partial remainder
    logic                  sign_q;
    logic                  sign_r;
    logic                  div0;
    logic                  done_r;
    logic [dout_WIDTH-1:0] quot_r;
    logic [din1_WIDTH-1:0] rem_r;

    assign bus.done      = done_r;
    assign bus.quotient  = quot_r;
    assign bus.remainder = rem_r;

    // Magnitudes: unsigned negation of a W-bit two's complement value is exact
    // in W bits, including -2^(W-1) which maps to the unsigned pattern 2^(W-1).
    logic [din0_WIDTH-1:0] mag0;
    logic [din1_WIDTH-1:0] mag1;
    assign mag0 = bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
    assign mag1 = bus.din1[din1_WIDTH-1] ? -bus.din1 : bus.din1;

    // One restoring step.
    logic [RW:0]           rem_shift;
    logic [RW:0]           dvs_ext;
    logic                  trial_ok;
    logic [RW-1:0]         rem_nxt;
    logic [din0_WIDTH-1:0] dvd_nxt;
    logic [din0_WIDTH-1:0] q_fix;
    logic [RW-1:0]         r_fix;

    assign rem_shift = {rem, dvd[din0_WIDTH-1]};
    assign dvs_ext   = (RW+1)'(dvs);
    assign trial_ok  = (rem_shift >= dvs_ext);
    // A successful trial leaves a value below the divisor, so the low RW bits
    // of the difference are the whole result.
    assign rem_nxt   = trial_ok ? (rem_shift[RW-1:0] - dvs_ext[RW-1:0]) : rem_shift[RW-1:0];
    assign dvd_nxt   = {dvd[din0_WIDTH-2:0], trial_ok};

    // Sign fix on the final iteration's values.
    assign q_fix = sign_q ? -dvd_nxt : dvd_nxt;
    assign r_fix = sign_r ? -rem_nxt : rem_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            div0   <= 1'b0;
            done_r <= 1'b0;
            quot_r <= '0;
            rem_r  <= '0;
        end else if (bus.ce) begin
            case (state)
                // DONE behaves like IDLE except it is where done was high;
                // accepting start here gives back-to-back issue.
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        dvd    <= mag0;
                        dvs    <= mag1;
                        rem    <= '0;
                        sign_q <= bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
                        sign_r <= bus.din0[din0_WIDTH-1];
                        div0   <= (bus.din1 == '0);
                        count  <= CW'(din0_WIDTH);
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    dvd   <= dvd_nxt;
                    rem   <= rem_nxt;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        // Divide by zero is pinned to -1; the remainder path
                        // already yields the dividend since nothing was subtracted.
                        quot_r <= div0 ? '1 : dout_WIDTH'($signed(q_fix));
                        rem_r  <= din1_WIDTH'($signed(r_fix));
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
